ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_pkg.sv | 23 ++
 rtl/ps2_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and default timing constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    // All timing values are counted in ce ticks (8 MHz nominal).
    localparam int DEF_INHIBIT   = 800;
    localparam int DEF_TMO_START = 120000;
    localparam int DEF_TMO_FRAME = 16000;
    localparam int TMR_W         = 17;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 lines plus a ce-qualified falling-edge detector
// on the PS/2 clock; shared with the keyboard receiver.
module ps2_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic [1:0] lines,
    output logic       clk_fall
);

    logic [1:0] meta;
    logic [1:0] sync;
    logic       clk_prev;

    // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta     <= 2'b11;
            sync     <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            meta <= ps2;
            sync <= meta;
            if (ce) begin
                clk_prev <= sync[0];
            end
        end
    end

    assign lines    = sync;
    assign clk_fall = ce & clk_prev & ~sync[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibit, request-to-send, device-clocked 8O1 frame, ACK check
// and line release, with start and frame timeouts.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT   = DEF_INHIBIT,
    parameter int TMO_START = DEF_TMO_START,
    parameter int TMO_FRAME = DEF_TMO_FRAME
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic       ps2ClkOe,
    output logic       ps2DatOe,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] fsm_state
);

    localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT - 1);
    localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(TMO_START - 1);
    localparam logic [TMR_W-1:0] FRAME_LAST   = TMR_W'(TMO_FRAME - 1);
    localparam logic [TMR_W-1:0] TMR_MAX      = '1;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] frame_q;
    logic [9:0]       shreg_q;
    logic             cur_bit_q;
    logic [3:0]       bit_cnt_q;
    logic             done_q;
    logic             error_q;

    logic             done_d;
    logic             error_d;
    logic             load_en;
    logic             shift_en;
    logic             frame_clr;

    logic [1:0]       lines;
    logic             clk_fall;

    ps2_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ps2      (ps2),
        .lines    (lines),
        .clk_fall (clk_fall)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            error_q <= error_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (ce && timer_q != TMR_MAX) begin
                timer_q <= timer_q + 1'b1;
            end
            // Frame timer spans edge 1 to edge 11, across the SHIFT->ACK boundary.
            if (frame_clr) begin
                frame_q <= '0;
            end else if (ce && frame_q != TMR_MAX) begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    // Shift register holds {stop, parity, data}; cur_bit is the level currently driven.
    always_ff @(posedge clock) begin
        if (load_en) begin
            shreg_q   <= {1'b1, odd_parity(data), data};
            cur_bit_q <= 1'b0;
            bit_cnt_q <= '0;
        end else if (shift_en) begin
            cur_bit_q <= shreg_q[0];
            shreg_q   <= {1'b1, shreg_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        frame_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (ce && timer_q >= INHIBIT_LAST) begin
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (ce) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == 4'd0) begin
                        frame_clr = 1'b1;
                    end
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end else if (ce && bit_cnt_q == 4'd0 && timer_q >= START_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (ce && bit_cnt_q != 4'd0 && frame_q >= FRAME_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (lines[1]) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else if (ce && frame_q >= FRAME_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (lines == 2'b11) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (ce && timer_q >= FRAME_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the registered state, so both drivers are off whenever IDLE.
    assign ps2ClkOe  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    assign ps2DatOe  = ((state_q == ST_RTS) || (state_q == ST_SHIFT) || (state_q == ST_ACK))
                       && !cur_bit_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign fsm_state = state_q;

endmodule
